// File: rtl/ps2_rx_pkg.sv
// rtl/ps2_rx_pkg.sv - shared constants and state encoding for the PS/2 packet receiver
package ps2_rx_pkg;

  localparam int PS2_DATA_BITS        = 8;
  localparam int PS2_MAX_PACKET_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_DATA_IN    = 3'd2,
    ST_PARITY_IN  = 3'd3,
    ST_STOP_IN    = 3'd4
  } ps2_rx_state_t;

endpackage

// File: rtl/ps2_rx_watchdog.sv
// rtl/ps2_rx_watchdog.sv - stall counter that flags a frame with no PS/2 clock edge for TIMEOUT_CYCLES
module ps2_rx_watchdog import ps2_rx_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Count idle cycles while enabled; saturate at the limit so it never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/ps2_packet_receiver.sv
// rtl/ps2_packet_receiver.sv - PS/2 device-to-host packet receiver; watchdog enabled by PS2_RX_TIMEOUT_EN
module ps2_packet_receiver import ps2_rx_pkg::*; #(
  parameter int PACKET_BYTES   = 1,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wait_for_incoming_data,
  input  logic                                start_receiving_data,
  input  logic                                ps2_clk_posedge,
  input  logic                                ps2_clk_negedge,
  input  logic                                ps2_data,
  output logic [PS2_DATA_BITS*PACKET_BYTES-1:0] received_data,
  output logic                                received_data_en,
  output logic                                parity_error,
  output logic                                framing_error,
  output logic                                timeout_error,
  output logic                                busy
);

  localparam int PKT_W = PS2_DATA_BITS * PACKET_BYTES;
  localparam int IDX_W = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_BYTES - 1);

  ps2_rx_state_t state, state_next;

  logic [2:0]               bit_cnt;
  logic [PS2_DATA_BITS-1:0] shift_reg;
  logic                     parity_bit;
  logic [IDX_W-1:0]         byte_idx;
  logic [PKT_W-1:0]         packet_buf;
  logic [PKT_W-1:0]         packet_next;

  logic shift_en, parity_cap, store_byte, commit, idx_clear, idx_inc;
  logic en_next, perr_next, ferr_next, terr_next;
  logic parity_ok;
  logic timeout_expire;

  // Reserved strobe and watchdog limit are deliberately unused in some builds.
  logic unused_ok;
  assign unused_ok = ps2_clk_negedge ^ (TIMEOUT_CYCLES == 0);

  // Odd parity: data plus parity bit must hold an odd number of ones.
  assign parity_ok = ^{shift_reg, parity_bit};
  assign busy      = (state != ST_IDLE);

`ifdef PS2_RX_TIMEOUT_EN
  logic wd_clear, wd_enable;

  assign wd_clear  = ps2_clk_posedge || (state == ST_IDLE);
  assign wd_enable = (state == ST_DATA_IN) || (state == ST_PARITY_IN) ||
                     (state == ST_STOP_IN) ||
                     ((state == ST_WAIT_START) && (byte_idx != '0));

  ps2_rx_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (timeout_expire)
  );

  // Register the watchdog abort pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timeout_error <= 1'b0;
    else        timeout_error <= terr_next;
  end
`else
  assign timeout_expire = 1'b0;
  assign timeout_error  = 1'b0;
`endif

  // Merge the current byte into the partially assembled packet at its slot.
  always_comb begin
    packet_next = packet_buf;
    for (int i = 0; i < PACKET_BYTES; i++) begin
      if (byte_idx == IDX_W'(i)) packet_next[PS2_DATA_BITS*i +: PS2_DATA_BITS] = shift_reg;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath control; a strobe always beats a watchdog expiry.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    parity_cap = 1'b0;
    store_byte = 1'b0;
    commit     = 1'b0;
    idx_clear  = 1'b0;
    idx_inc    = 1'b0;
    en_next    = 1'b0;
    perr_next  = 1'b0;
    ferr_next  = 1'b0;
    terr_next  = 1'b0;

    if ((state != ST_IDLE) && timeout_expire && !ps2_clk_posedge) begin
      terr_next  = 1'b1;
      idx_clear  = 1'b1;
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!received_data_en) begin
            if (wait_for_incoming_data)    state_next = ST_WAIT_START;
            else if (start_receiving_data) state_next = ST_DATA_IN;
          end
        end
        ST_WAIT_START: begin
          if (ps2_clk_posedge && !ps2_data)                   state_next = ST_DATA_IN;
          else if ((byte_idx == '0) && !wait_for_incoming_data) state_next = ST_IDLE;
        end
        ST_DATA_IN: begin
          if (ps2_clk_posedge) begin
            shift_en = 1'b1;
            if (bit_cnt == 3'd7) state_next = ST_PARITY_IN;
          end
        end
        ST_PARITY_IN: begin
          if (ps2_clk_posedge) begin
            parity_cap = 1'b1;
            state_next = ST_STOP_IN;
          end
        end
        ST_STOP_IN: begin
          if (ps2_clk_posedge) begin
            if (!parity_ok) begin
              perr_next  = 1'b1;
              idx_clear  = 1'b1;
              state_next = ST_IDLE;
            end else if (!ps2_data) begin
              ferr_next  = 1'b1;
              idx_clear  = 1'b1;
              state_next = ST_IDLE;
            end else if (byte_idx == LAST_IDX) begin
              store_byte = 1'b1;
              commit     = 1'b1;
              en_next    = 1'b1;
              idx_clear  = 1'b1;
              state_next = ST_IDLE;
            end else begin
              store_byte = 1'b1;
              idx_inc    = 1'b1;
              state_next = ST_WAIT_START;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Shift register, counters, packet assembly and registered status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt          <= '0;
      shift_reg        <= '0;
      parity_bit       <= 1'b0;
      byte_idx         <= '0;
      packet_buf       <= '0;
      received_data    <= '0;
      received_data_en <= 1'b0;
      parity_error     <= 1'b0;
      framing_error    <= 1'b0;
    end else begin
      if (state != ST_DATA_IN) bit_cnt <= '0;
      else if (shift_en)       bit_cnt <= bit_cnt + 3'd1;
      if (shift_en)   shift_reg  <= {ps2_data, shift_reg[PS2_DATA_BITS-1:1]};
      if (parity_cap) parity_bit <= ps2_data;
      if (idx_clear)    byte_idx <= '0;
      else if (idx_inc) byte_idx <= byte_idx + 1'b1;
      if (store_byte) packet_buf    <= packet_next;
      if (commit)     received_data <= packet_next;
      received_data_en <= en_next;
      parity_error     <= perr_next;
      framing_error    <= ferr_next;
    end
  end

endmodule

// File: tb/tb_ps2_packet_receiver.sv
// tb/tb_ps2_packet_receiver.sv - self-checking bench for ps2_packet_receiver (1-byte and 3-byte instances)
module tb_ps2_packet_receiver;

  localparam int K_OK   = 0;
  localparam int K_PERR = 1;
  localparam int K_FERR = 2;
  localparam int K_TOUT = 3;

  typedef struct {
    int          kind;
    logic [23:0] data;
  } exp_t;

  typedef struct {
    int          kind;
    logic [23:0] data;
    int          npulse;
    logic        busy;
  } obs_t;

  typedef struct {
    logic [7:0] b;
    logic       par_ok;
    logic       stop;
    int         kind;
    logic [7:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic w1 = 0, s1 = 0, p1 = 0, d1 = 1;
  logic [7:0] rd1;
  logic en1, pe1, fe1, te1, b1;

  logic w3 = 0, s3 = 0, p3 = 0, d3 = 1;
  logic [23:0] rd3;
  logic en3, pe3, fe3, te3, b3;

  logic neg_strobe = 1'b0;

  exp_t exp1[$], exp3[$];
  obs_t obs1[$], obs3[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_packet_receiver #(.PACKET_BYTES(1), .TIMEOUT_CYCLES(100)) dut1 (
    .clk(clk), .reset(reset), .wait_for_incoming_data(w1), .start_receiving_data(s1),
    .ps2_clk_posedge(p1), .ps2_clk_negedge(neg_strobe), .ps2_data(d1),
    .received_data(rd1), .received_data_en(en1), .parity_error(pe1),
    .framing_error(fe1), .timeout_error(te1), .busy(b1)
  );

  ps2_packet_receiver #(.PACKET_BYTES(3), .TIMEOUT_CYCLES(100)) dut3 (
    .clk(clk), .reset(reset), .wait_for_incoming_data(w3), .start_receiving_data(s3),
    .ps2_clk_posedge(p3), .ps2_clk_negedge(neg_strobe), .ps2_data(d3),
    .received_data(rd3), .received_data_en(en3), .parity_error(pe3),
    .framing_error(fe3), .timeout_error(te3), .busy(b3)
  );

  always @(negedge clk) begin
    if (reset && (en1 || pe1 || fe1 || te1))
      obs1.push_back('{kind: (en1 ? K_OK : pe1 ? K_PERR : fe1 ? K_FERR : K_TOUT),
                       data: {16'h0, rd1},
                       npulse: int'(en1) + int'(pe1) + int'(fe1) + int'(te1), busy: b1});
    if (reset && (en3 || pe3 || fe3 || te3))
      obs3.push_back('{kind: (en3 ? K_OK : pe3 ? K_PERR : fe3 ? K_FERR : K_TOUT),
                       data: rd3,
                       npulse: int'(en3) + int'(pe3) + int'(fe3) + int'(te3), busy: b3});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic set_wait(input int sel, input logic v);
    if (sel == 1) w1 = v; else w3 = v;
  endtask

  task automatic drive_bit(input int sel, input logic b);
    @(negedge clk);
    if (sel == 1) begin d1 = b; p1 = 1'b1; end
    else          begin d3 = b; p3 = 1'b1; end
    @(negedge clk);
    if (sel == 1) p1 = 1'b0; else p3 = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] b, input logic par_ok,
                            input logic stop_bit, input logic arm, input logic with_start);
    if (arm) set_wait(sel, 1'b1);
    if (with_start) drive_bit(sel, 1'b0);
    set_wait(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i]);
    drive_bit(sel, par_ok ? ~(^b) : (^b));
    drive_bit(sel, stop_bit);
  endtask

  task automatic drain(input int sel, input string tag);
    exp_t e;
    obs_t o;
    int   n_obs;
    repeat (2) @(negedge clk);
    forever begin
      if (sel == 1) begin
        if (exp1.size() == 0) break;
        e = exp1.pop_front();
        n_obs = obs1.size();
      end else begin
        if (exp3.size() == 0) break;
        e = exp3.pop_front();
        n_obs = obs3.size();
      end
      checks++;
      if (n_obs == 0) begin
        errors++;
        $display("FAIL %s response: got none required kind %0d", tag, e.kind);
      end else begin
        if (sel == 1) o = obs1.pop_front(); else o = obs3.pop_front();
        check({tag, " kind"}, o.kind, e.kind);
        check({tag, " data"}, {8'h0, o.data}, {8'h0, e.data});
        check({tag, " pulse count"}, o.npulse, 1);
        check({tag, " busy at pulse"}, {31'h0, o.busy}, 32'h0);
      end
    end
    n_obs = (sel == 1) ? obs1.size() : obs3.size();
    check({tag, " extra responses"}, n_obs, 0);
    if (sel == 1) obs1.delete(); else obs3.delete();
  endtask

  vec_t vecs[8];
  logic [7:0] last1;
  logic [7:0] tbyte;
  int cyc;

  initial begin
    vecs[0] = '{b: 8'hA5, par_ok: 1, stop: 1, kind: K_OK,   exp_data: 8'hA5};
    vecs[1] = '{b: 8'h3C, par_ok: 0, stop: 1, kind: K_PERR, exp_data: 8'hA5};
    vecs[2] = '{b: 8'h55, par_ok: 1, stop: 1, kind: K_OK,   exp_data: 8'h55};
    vecs[3] = '{b: 8'h12, par_ok: 1, stop: 0, kind: K_FERR, exp_data: 8'h55};
    vecs[4] = '{b: 8'h34, par_ok: 0, stop: 0, kind: K_PERR, exp_data: 8'h55};
    vecs[5] = '{b: 8'hFF, par_ok: 1, stop: 1, kind: K_OK,   exp_data: 8'hFF};
    vecs[6] = '{b: 8'h00, par_ok: 1, stop: 1, kind: K_OK,   exp_data: 8'h00};
    vecs[7] = '{b: 8'h80, par_ok: 0, stop: 1, kind: K_PERR, exp_data: 8'h00};

    repeat (3) @(negedge clk);
    check("reset rd1", {24'h0, rd1}, 0);
    check("reset rd3", {8'h0, rd3}, 0);
    check("reset en1", {31'h0, en1}, 0);
    check("reset pe1", {31'h0, pe1}, 0);
    check("reset fe1", {31'h0, fe1}, 0);
    check("reset te1", {31'h0, te1}, 0);
    check("reset busy1", {31'h0, b1}, 0);
    check("reset en3", {31'h0, en3}, 0);
    check("reset busy3", {31'h0, b3}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      exp1.push_back('{kind: vecs[i].kind, data: {16'h0, vecs[i].exp_data}});
      send_frame(1, vecs[i].b, vecs[i].par_ok, vecs[i].stop, 1'b1, 1'b1);
      drain(1, $sformatf("vec%0d", i));
      check($sformatf("vec%0d busy after", i), {31'h0, b1}, 0);
    end
    last1 = 8'h00;

    // Start bit already consumed: begin at data bit 0.
    exp1.push_back('{kind: K_OK, data: 24'hC3});
    @(negedge clk) s1 = 1'b1;
    @(negedge clk) s1 = 1'b0;
    send_frame(1, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
    drain(1, "start_receiving");

    // Both requests high: wait_for_incoming_data wins.
    exp1.push_back('{kind: K_OK, data: 24'h5A});
    @(negedge clk) begin w1 = 1'b1; s1 = 1'b1; end
    @(negedge clk) s1 = 1'b0;
    send_frame(1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1);
    drain(1, "both_requests");

    // Request held through completion is ignored while received_data_en is high.
    exp1.push_back('{kind: K_OK, data: 24'h96});
    w1 = 1'b1;
    tbyte = 8'h96;
    drive_bit(1, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1, tbyte[i]);
    drive_bit(1, ~(^tbyte));
    @(negedge clk) begin d1 = 1'b1; p1 = 1'b1; end
    @(negedge clk) p1 = 1'b0;
    check("en pulse after stop", {31'h0, en1}, 1);
    @(negedge clk);
    check("request ignored during en", {31'h0, b1}, 0);
    @(negedge clk);
    check("rearm after en", {31'h0, b1}, 1);
    w1 = 1'b0;
    repeat (2) @(negedge clk);
    check("wait drop returns idle", {31'h0, b1}, 0);
    drain(1, "en_ignore");
    last1 = 8'h96;

    // Three-byte packet; wait stays low between bytes.
    exp3.push_back('{kind: K_OK, data: 24'hF01008});
    send_frame(3, 8'h08, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("busy between bytes", {31'h0, b3}, 1);
    check("no early packet pulse", obs3.size(), 0);
    send_frame(3, 8'h10, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(3, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b1);
    drain(3, "pkt3_a");

    // Parity error on byte 1 discards the packet and restarts at byte 0.
    exp3.push_back('{kind: K_PERR, data: 24'hF01008});
    send_frame(3, 8'h08, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(3, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1);
    drain(3, "pkt3_perr");
    check("busy3 after perr", {31'h0, b3}, 0);
    exp3.push_back('{kind: K_OK, data: 24'h332211});
    send_frame(3, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(3, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(3, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1);
    drain(3, "pkt3_b");

    // Stall after four data bits.
    tbyte = 8'h6B;
`ifdef PS2_RX_TIMEOUT_EN
    exp1.push_back('{kind: K_TOUT, data: {16'h0, last1}});
    w1 = 1'b1;
    drive_bit(1, 1'b0);
    w1 = 1'b0;
    for (int i = 0; i < 4; i++) drive_bit(1, tbyte[i]);
    cyc = 1;
    while (!te1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout pulse seen", {31'h0, te1}, 1);
    check("timeout latency", cyc, 101);
    @(negedge clk);
    check("idle after timeout", {31'h0, b1}, 0);
    drain(1, "timeout");
    w1 = 1'b1;
    repeat (150) @(negedge clk);
    check("no timeout waiting first start", {31'h0, b1}, 1);
    check("no pulse waiting first start", obs1.size(), 0);
    w1 = 1'b0;
    repeat (2) @(negedge clk);
    check("idle after wait drop", {31'h0, b1}, 0);
`else
    exp1.push_back('{kind: K_OK, data: {16'h0, tbyte}});
    w1 = 1'b1;
    drive_bit(1, 1'b0);
    w1 = 1'b0;
    for (int i = 0; i < 4; i++) drive_bit(1, tbyte[i]);
    repeat (150) @(negedge clk);
    check("stalled frame still busy", {31'h0, b1}, 1);
    check("no timeout pulse", obs1.size(), 0);
    for (int i = 4; i < 8; i++) drive_bit(1, tbyte[i]);
    drive_bit(1, ~(^tbyte));
    drive_bit(1, 1'b1);
    drain(1, "stall_resume");
`endif

    // Reset during byte 2 of a 3-byte packet.
    exp3.push_back('{kind: K_OK, data: 24'h665544});
    send_frame(3, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(3, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(3, 8'h66, 1'b1, 1'b1, 1'b0, 1'b1);
    drain(3, "pkt3_c");
    send_frame(3, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(3, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1);
    tbyte = 8'h03;
    drive_bit(3, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(3, tbyte[i]);
    check("busy3 mid packet", {31'h0, b3}, 1);
    #2 reset = 1'b0;
    #1;
    check("async reset rd3", {8'h0, rd3}, 0);
    check("async reset busy3", {31'h0, b3}, 0);
    check("async reset pulses3", {28'h0, en3, pe3, fe3, te3}, 0);
    check("async reset rd1", {24'h0, rd1}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("no pulse after reset", obs3.size(), 0);
    check("idle after reset", {31'h0, b3}, 0);

    drain(1, "final1");
    drain(3, "final3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
